// File: rtl/ram_be_pipe_pkg.sv
// ============================================================================
// Module   : ram_be_pipe_pkg
// Brief    : Shared constants, FSM state type and helpers for ram_be_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ram_be_pipe_pkg;

    localparam int LANE_BITS = 8;
    localparam int RL_MIN    = 1;
    localparam int RL_MAX    = 3;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int byte_lanes(input int data_width);
        return data_width / LANE_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_read_pipe.sv
// ============================================================================
// Module   : ram_read_pipe
// Brief    : DEPTH-stage {valid,data} shift register; data advances only with
//            its valid bit so the last stage holds the most recent result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_read_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH:0] src_d;
        logic [WIDTH:0] stage_q;

        if (i == 0) begin : g_head
            assign src_d = {in_valid_i, in_data_i};
        end else begin : g_tail
            assign src_d = g_stage[i-1].stage_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q <= '0;
            end else begin
                stage_q[WIDTH] <= src_d[WIDTH];
                if (src_d[WIDTH]) begin
                    stage_q[WIDTH-1:0] <= src_d[WIDTH-1:0];
                end
            end
        end
    end

    assign out_valid_o = g_stage[DEPTH-1].stage_q[WIDTH];
    assign out_data_o  = g_stage[DEPTH-1].stage_q[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/ram_be_pipe.sv
// ============================================================================
// Module   : ram_be_pipe
// Brief    : 1R1W scratchpad with byte enables, pipelined read and post-reset
//            init sweep. Macro RAM_BE_PIPE_FWD_EN enables same-address
//            read-during-write forwarding of the merged word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_be_pipe
    import ram_be_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         read_req,
    input  logic [ADDR_WIDTH-1:0]        read_addr,
    output logic signed [DATA_WIDTH-1:0] read_data,
    output logic                         read_valid,
    input  logic                         write_req,
    input  logic [ADDR_WIDTH-1:0]        write_addr,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic [DATA_WIDTH/8-1:0]      write_be,
    output logic                         init_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = byte_lanes(DATA_WIDTH);

    if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX || (DATA_WIDTH % LANE_BITS) != 0)
    begin : g_param_check
        $error("ram_be_pipe: illegal DATA_WIDTH or READ_LATENCY");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_en, wr_en;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] pipe_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        init_busy = 1'b1;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        if (state_q == ST_READY) begin
            init_busy = 1'b0;
            rd_en     = read_req;
            wr_en     = write_req;
        end
    end

    // Array is deliberately outside reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (write_be[b]) begin
                    mem_q[write_addr][b*LANE_BITS +: LANE_BITS] <= write_data[b*LANE_BITS +: LANE_BITS];
                end
            end
        end
    end

`ifdef RAM_BE_PIPE_FWD_EN
    always_comb begin
        rd_word = mem_q[read_addr];
        if (wr_en && (write_addr == read_addr)) begin
            for (int b = 0; b < NB; b++) begin
                if (write_be[b]) begin
                    rd_word[b*LANE_BITS +: LANE_BITS] = write_data[b*LANE_BITS +: LANE_BITS];
                end
            end
        end
    end
`else
    assign rd_word = mem_q[read_addr];
`endif

    ram_read_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (DATA_WIDTH)
    ) u_read_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (rd_en),
        .in_data_i   (rd_word),
        .out_valid_o (read_valid),
        .out_data_o  (pipe_data)
    );

    assign read_data = pipe_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_be_pipe.sv
// ============================================================================
// Module   : tb_ram_be_pipe
// Brief    : Scoreboard bench driving latency-1 and latency-3 instances with
//            identical stimulus (DEPTH=16, INIT_VALUE=0).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_be_pipe;

    localparam int             DW    = 32;
    localparam int             AW    = 4;
    localparam int             DEPTH = 16;
    localparam logic [DW-1:0]  INITV = '0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_req = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic          write_req = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic [3:0]    write_be = '0;

    logic signed [DW-1:0] rd1, rd3;
    logic                 v1, v3, b1, b3;

    always #5 clk = ~clk;

    ram_be_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .INIT_VALUE(INITV)) u_dut1 (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .read_data(rd1), .read_valid(v1), .write_req(write_req), .write_addr(write_addr),
        .write_data(write_data), .write_be(write_be), .init_busy(b1));

    ram_be_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3), .INIT_VALUE(INITV)) u_dut3 (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .read_data(rd3), .read_valid(v3), .write_req(write_req), .write_addr(write_addr),
        .write_data(write_data), .write_be(write_be), .init_busy(b3));

    typedef struct {
        int            lat;
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] last_d [2];
    logic          m_ready = 1'b0;
    int            sweep = 0;
    int            edge_cnt = 0;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic check_port(input int lat, input logic v, input logic [DW-1:0] d);
        int   idx;
        logic want;
        int   li;
        idx = -1;
        li  = (lat == 1) ? 0 : 1;
        foreach (sb[i]) if (idx < 0 && sb[i].lat == lat) idx = i;
        want = (idx >= 0) && (sb[idx].due == edge_cnt);
        chk($sformatf("valid_l%0d", lat), {31'd0, v}, {31'd0, want});
        if (want) begin
            if (v) chk($sformatf("data_l%0d", lat), d, sb[idx].data);
            last_d[li] = sb[idx].data;
            sb.delete(idx);
        end else if (!v) begin
            chk($sformatf("hold_l%0d", lat), d, last_d[li]);
        end
    endtask

    task automatic step();
        logic [DW-1:0] w;
        @(posedge clk);
        edge_cnt++;
        if (!reset) begin
            if (m_ready) begin
                if (read_req) begin
                    w = mdl[read_addr];
`ifdef RAM_BE_PIPE_FWD_EN
                    if (write_req && write_addr == read_addr)
                        for (int b = 0; b < 4; b++)
                            if (write_be[b]) w[8*b +: 8] = write_data[8*b +: 8];
`endif
                    sb.push_back('{1, edge_cnt, w});
                    sb.push_back('{3, edge_cnt + 2, w});
                end
                if (write_req)
                    for (int b = 0; b < 4; b++)
                        if (write_be[b]) mdl[write_addr][8*b +: 8] = write_data[8*b +: 8];
            end else begin
                sweep++;
                if (sweep == DEPTH) begin
                    m_ready = 1'b1;
                    foreach (mdl[i]) mdl[i] = INITV;
                end
            end
        end
        @(negedge clk);
        chk("busy_l1", {31'd0, b1}, {31'd0, !m_ready});
        chk("busy_l3", {31'd0, b3}, {31'd0, !m_ready});
        check_port(1, v1, rd1);
        check_port(3, v3, rd3);
    endtask

    task automatic drive(input logic rr, input logic [AW-1:0] ra, input logic wr,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] be);
        read_req   = rr;
        read_addr  = ra;
        write_req  = wr;
        write_addr = wa;
        write_data = wd;
        write_be   = be;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, 4'h0);
    endtask

    // Asynchronous assertion: outputs must clear without waiting for an edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        sb.delete();
        last_d[0] = '0;
        last_d[1] = '0;
        m_ready   = 1'b0;
        sweep     = 0;
        chk("rst_valid_l1", {31'd0, v1}, 32'd0);
        chk("rst_valid_l3", {31'd0, v3}, 32'd0);
        chk("rst_busy", {31'd0, b1 & b3}, 32'd1);
        chk("rst_data_l3", rd3, '0);
    endtask

    initial begin
        last_d[0] = '0;
        last_d[1] = '0;
        foreach (mdl[i]) mdl[i] = 'x;
        @(negedge clk);
        idle(2);
        reset = 1'b0;

        // Requests during the sweep must be dropped.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 4'd9, 1'b1, 4'd9, 32'hFFFF_FFFF, 4'hF);
        drive(1'b1, 4'd5, 1'b0, '0, '0, 4'h0);
        idle(3);

        drive(1'b0, '0, 1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101);
        drive(1'b1, 4'd3, 1'b0, '0, '0, 4'h0);
        drive(1'b0, '0, 1'b1, 4'd7, 32'h0000_0001, 4'hF);
        drive(1'b1, 4'd7, 1'b1, 4'd7, 32'h1234_5678, 4'hF);
        drive(1'b1, 4'd9, 1'b0, '0, '0, 4'h0);
        idle(3);

        drive(1'b1, 4'd3, 1'b0, '0, '0, 4'h0);
        drive(1'b1, 4'd7, 1'b0, '0, '0, 4'h0);
        drive(1'b1, 4'd9, 1'b0, '0, '0, 4'h0);
        drive(1'b1, 4'd5, 1'b0, '0, '0, 4'h0);
        idle(4);

        for (int i = 0; i < 80; i++)
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  32'($urandom), 4'($urandom_range(0, 15)));
        idle(4);

        drive(1'b1, 4'd3, 1'b0, '0, '0, 4'h0);
        read_req = 1'b0;
        do_reset();
        idle(2);
        reset = 1'b0;
        idle(7);
        do_reset();
        idle(1);
        reset = 1'b0;
        idle(DEPTH);

        drive(1'b1, 4'd3, 1'b0, '0, '0, 4'h0);
        drive(1'b1, 4'd7, 1'b0, '0, '0, 4'h0);
        idle(4);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_be_pipe.md
# ram_be_pipe

Parameterised single-read/single-write scratchpad RAM for the NPU datapath, successor to the flat word RAM. It adds per-byte write enables, a configurable read latency with a `read_valid` strobe, and a hardware init sweep that clears the array after reset. It sits under the NPU top as the storage for weight, activation and partial-sum buffers.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 10: address width; depth `DEPTH = 1<<ADDR_WIDTH` words, exactly.
- `READ_LATENCY`, 1: clock edges from accepted `read_req` to `read_valid`; legal range 1..3.
- `INIT_VALUE`, 0: word value written to every address by the init sweep.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `read_req` in 1: read request, sampled on `clk` rising edge.
- `read_addr` in ADDR_WIDTH: read address.
- `read_data` out DATA_WIDTH, signed: read result, meaningful when `read_valid` is 1.
- `read_valid` out 1: `read_data` carries the result of a request.
- `write_req` in 1: write request.
- `write_addr` in ADDR_WIDTH: write address.
- `write_data` in DATA_WIDTH: write data.
- `write_be` in DATA_WIDTH/8: byte enables; bit k enables byte `[8k+7:8k]`.
- `init_busy` out 1: init sweep in progress; requests are ignored.

## Operation
- FSM has two states, INIT and READY. `reset` forces INIT with the sweep counter at 0.
- INIT:
  - Each cycle writes `INIT_VALUE` to `mem[counter]`, then increments the counter.
  - After address `DEPTH-1` is written, the FSM moves to READY.
  - The sweep takes exactly DEPTH cycles after reset deassertion.
  - `init_busy` = 1 throughout INIT.
  - `read_req` and `write_req` are dropped: no array update and no `read_valid`.
- READY: `init_busy` = 0. One read and one write can be accepted per cycle, independently.
- Write:
  - On an edge with `write_req` = 1, bytes of `mem[write_addr]` with `write_be[k]` = 1 take `write_data`; all other bytes are unchanged.
  - `write_be` = 0 is a legal no-op.
- Read: on an edge with `read_req` = 1, `mem[read_addr]` is sampled into a READ_LATENCY-deep pipeline. The valid bit travels alongside the data.
- Read-during-write to the same address on the same edge: the read returns the pre-write word by default. See Configuration for the alternative.
- Array contents are not reset by `reset`; only the sweep clears them.
- Reset mid-operation, including mid-sweep: the pipeline is flushed, `read_valid` drops immediately, and the sweep restarts from address 0.

## Timing
- Reset values: `read_data` = 0, `read_valid` = 0, `init_busy` = 1.
- Read accepted at edge N: `read_valid` = 1 and data presented after edge N+READ_LATENCY-1, so the value is sampled at edge N+READ_LATENCY.
- `read_valid` is high for exactly one cycle per accepted request. Back-to-back requests give back-to-back valids, with full throughput.
- `read_data` holds its last valid value while `read_valid` = 0.
- A write at edge N is visible to a read accepted at edge N+1 or later.
- `init_busy` falls on the edge that writes address DEPTH-1. A request in the following cycle is accepted.

## Configuration
- `RAM_BE_PIPE_FWD_EN` defined: same-address read-during-write returns the merged word, i.e. old word with the enabled bytes replaced by `write_data`. Latency is unchanged.
- Not defined: the read returns the old word, and no forwarding logic is built.

## Structure
- A shared package holds:
  - the `DATA_WIDTH/8` byte-lane constant,
  - the FSM state enum (INIT, READY),
  - the `READ_LATENCY` range limits.
- The read pipeline is a natural sub-module, `ram_read_pipe`: a parameterised depth×(DATA_WIDTH+1) shift register with async reset.

## Test plan
- DEPTH=16, INIT_VALUE=0: release reset. `init_busy` stays high for 16 cycles. A read of address 5 then returns 0 with `read_valid` = 1 one cycle later.
- Address 3 holds 0. Write `0xAABBCCDD` with `write_be` = `4'b0101`, then read address 3. Expect `0x00BB00DD`.
- READ_LATENCY=3: read at edge 10 gives `read_valid` at edge 13. Reads on 4 consecutive edges give 4 consecutive valids in order.
- Same-edge write `0x12345678` (all bytes) and read of address 7, which holds `0x1`:
  - without the macro, expect `0x1`;
  - with `RAM_BE_PIPE_FWD_EN`, expect `0x12345678`.
- Assert `reset` at sweep count 7 with a read in flight. `read_valid` goes to 0 at once, and `init_busy` stays high for a full 16 cycles after release.
- Issue `write_req` and `read_req` during INIT. There is no `read_valid`, and the written address reads back `INIT_VALUE` after the sweep.
